// File: rtl/input_stage_if.sv
// Sample-in / State0-out / State1-out handshake bundle for input_stage.
// Signal names match the original flat port list so bench and upstream wiring carry over unchanged.
interface input_stage_if #(
  parameter int unsigned NP    = 8,
  parameter int unsigned WF    = 5,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned DW = NP * WF;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          iMode;
  logic          iValid_AM_Sample;
  logic          oReady_AM_Sample;
  logic [DW-1:0] iData_AM_Sample;
  logic          oValid_BM_State0;
  logic          iReady_BM_State0;
  logic [DW-1:0] oData_BM_State0;
  logic          oValid_BM_State1;
  logic          iReady_BM_State1;
  logic [DW-1:0] oData_BM_State1;
  logic [CW-1:0] oCount;

  modport master (
    output iMode, iValid_AM_Sample, iData_AM_Sample, iReady_BM_State0, iReady_BM_State1,
    input  oReady_AM_Sample, oValid_BM_State0, oData_BM_State0,
           oValid_BM_State1, oData_BM_State1, oCount
  );

  modport slave (
    input  iMode, iValid_AM_Sample, iData_AM_Sample, iReady_BM_State0, iReady_BM_State1,
    output oReady_AM_Sample, oValid_BM_State0, oData_BM_State0,
           oValid_BM_State1, oData_BM_State1, oCount
  );
endinterface

// File: rtl/input_stage.sv
// Network input stage: 1-entry forward pipe register to State0, plus a training-mode
// replay FIFO feeding State1 for the hidden layer's weight update.
module input_stage #(
  parameter int unsigned NP    = 8,
  parameter int unsigned WF    = 5,
  parameter int unsigned DEPTH = 4
) (
  input logic          iCLK,
  input logic          iRST,
  input_stage_if.slave bus
);
  localparam int unsigned   DW   = NP * WF;
  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          s0_valid_q, s0_valid_d;
  logic [DW-1:0] s0_data_q, s0_data_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          s0free, in_ready, in_xfer, push, pop;

  always_comb begin
    s0free   = !s0_valid_q || bus.iReady_BM_State0;
    // Full FIFO only throttles training input; inference input keeps flowing.
    in_ready = !iRST && s0free && (!bus.iMode || (count_q != FULL));
    in_xfer  = bus.iValid_AM_Sample && in_ready;
    push     = in_xfer && bus.iMode;
    pop      = (count_q != '0) && bus.iReady_BM_State1;

    s0_valid_d = s0_valid_q;
    s0_data_d  = s0_data_q;
    if (in_xfer) begin
      s0_valid_d = 1'b1;
      s0_data_d  = bus.iData_AM_Sample;
    end else if (s0_valid_q && bus.iReady_BM_State0) begin
      s0_valid_d = 1'b0;
    end

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = bus.iData_AM_Sample;
      wptr_d        = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.oReady_AM_Sample = in_ready;
  assign bus.oValid_BM_State0 = s0_valid_q;
  assign bus.oData_BM_State0  = s0_data_q;
  assign bus.oValid_BM_State1 = (count_q != '0);
  assign bus.oData_BM_State1  = mem_q[rptr_q];
  assign bus.oCount           = count_q;
endmodule

// File: tb/tb_input_stage.sv
// Directed bench for input_stage: a per-cycle vector table for pipe/FIFO behaviour,
// then hand-written sequences for stall, mode switch and asynchronous reset.
module tb_input_stage;
  localparam int unsigned NP    = 8;
  localparam int unsigned WF    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = NP * WF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  input_stage_if #(.NP(NP), .WF(WF), .DEPTH(DEPTH)) bus ();

  input_stage #(.NP(NP), .WF(WF), .DEPTH(DEPTH)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus.slave)
  );

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.iValid_AM_Sample && bus.oReady_AM_Sample && bus.iMode && bus.oCount == 3'(DEPTH)))
        else $error("FAIL push_when_full count=%0d", bus.oCount);
      assert (!(bus.oValid_BM_State1 && bus.iReady_BM_State1 && bus.oCount == '0))
        else $error("FAIL pop_when_empty count=%0d", bus.oCount);
    end
  end

  function automatic logic [DW-1:0] mk(input logic [WF-1:0] k);
    return {NP{k}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic v, input logic [DW-1:0] d,
                       input logic r0, input logic r1);
    @(negedge clk);
    bus.iMode            = m;
    bus.iValid_AM_Sample = v;
    bus.iData_AM_Sample  = d;
    bus.iReady_BM_State0 = r0;
    bus.iReady_BM_State1 = r1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       mode, valid;
    logic [4:0] k;
    logic       r0, r1;
    logic       x_rdy, x_v0;
    logic [4:0] x_d0k;
    logic       x_v1;
    logic [4:0] x_d1k;
    logic [2:0] x_cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // mode valid k r0 r1 | rdy(before edge) v0 d0 v1 d1 cnt (after edge)
    tbl = '{
      '{0,1,1,1,0, 1,1,1, 0,0,0},
      '{0,1,2,1,0, 1,1,2, 0,0,0},
      '{0,1,3,1,0, 1,1,3, 0,0,0},
      '{0,0,0,1,0, 1,0,0, 0,0,0},
      '{1,1,4,1,0, 1,1,4, 1,4,1},
      '{1,1,5,1,0, 1,1,5, 1,4,2},
      '{1,1,6,1,0, 1,1,6, 1,4,3},
      '{1,1,7,1,0, 1,1,7, 1,4,4},
      '{1,1,8,1,0, 0,0,0, 1,4,4},
      '{1,1,8,1,1, 0,0,0, 1,5,3},
      '{1,1,8,1,0, 1,1,8, 1,5,4},
      '{1,0,0,1,1, 0,0,0, 1,6,3},
      '{1,1,9,1,1, 1,1,9, 1,7,3},
      '{1,0,0,1,1, 1,0,0, 1,8,2},
      '{1,0,0,1,1, 1,0,0, 1,9,1},
      '{1,0,0,1,1, 1,0,0, 0,0,0}
    };

    bus.iMode            = 1'b0;
    bus.iValid_AM_Sample = 1'b0;
    bus.iData_AM_Sample  = '0;
    bus.iReady_BM_State0 = 1'b0;
    bus.iReady_BM_State1 = 1'b0;

    #3;
    chk("rst_ready", bus.oReady_AM_Sample, 0);
    chk("rst_v0",    bus.oValid_BM_State0, 0);
    chk("rst_v1",    bus.oValid_BM_State1, 0);
    chk("rst_cnt",   bus.oCount, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].mode, tbl[i].valid, mk(tbl[i].k), tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("vec%0d_ready", i), bus.oReady_AM_Sample, tbl[i].x_rdy);
      tick;
      chk($sformatf("vec%0d_v0", i), bus.oValid_BM_State0, tbl[i].x_v0);
      if (tbl[i].x_v0) chk($sformatf("vec%0d_d0", i), bus.oData_BM_State0, mk(tbl[i].x_d0k));
      chk($sformatf("vec%0d_v1", i), bus.oValid_BM_State1, tbl[i].x_v1);
      if (tbl[i].x_v1) chk($sformatf("vec%0d_d1", i), bus.oData_BM_State1, mk(tbl[i].x_d1k));
      chk($sformatf("vec%0d_cnt", i), bus.oCount, tbl[i].x_cnt);
    end

    // State0 back-pressure: data held, input blocked, nothing lost or duplicated
    drive(0, 1, mk(10), 1, 0);
    tick;
    chk("stall_load_d0", bus.oData_BM_State0, mk(10));
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, mk(11), 0, 0);
      #1;
      chk("stall_ready", bus.oReady_AM_Sample, 0);
      tick;
      chk("stall_v0", bus.oValid_BM_State0, 1);
      chk("stall_d0", bus.oData_BM_State0, mk(10));
    end
    drive(0, 1, mk(11), 1, 0);
    #1;
    chk("release_ready", bus.oReady_AM_Sample, 1);
    tick;
    chk("release_v0", bus.oValid_BM_State0, 1);
    chk("release_d0", bus.oData_BM_State0, mk(11));
    drive(0, 0, '0, 1, 0);
    tick;
    chk("release_drain_v0", bus.oValid_BM_State0, 0);
    chk("release_cnt", bus.oCount, 0);

    // Mode 1 -> 0 with two entries queued
    drive(1, 1, mk(12), 1, 0);
    tick;
    drive(1, 1, mk(13), 1, 0);
    tick;
    chk("mode_cnt2", bus.oCount, 2);
    drive(0, 1, mk(14), 1, 0);
    tick;
    chk("mode_inf_cnt", bus.oCount, 2);
    chk("mode_inf_d0", bus.oData_BM_State0, mk(14));
    chk("mode_inf_d1", bus.oData_BM_State1, mk(12));
    drive(0, 0, '0, 1, 1);
    tick;
    chk("mode_pop1_cnt", bus.oCount, 1);
    chk("mode_pop1_d1", bus.oData_BM_State1, mk(13));
    drive(0, 0, '0, 1, 1);
    tick;
    chk("mode_pop2_cnt", bus.oCount, 0);
    chk("mode_pop2_v1", bus.oValid_BM_State1, 0);

    // Full FIFO does not block inference input
    for (int k = 16; k < 20; k++) begin
      drive(1, 1, mk(5'(k)), 1, 0);
      tick;
    end
    chk("full_cnt", bus.oCount, 4);
    drive(0, 1, mk(20), 1, 0);
    #1;
    chk("full_inf_ready", bus.oReady_AM_Sample, 1);
    tick;
    chk("full_inf_d0", bus.oData_BM_State0, mk(20));
    chk("full_inf_cnt", bus.oCount, 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 1, 1);
      #1;
      chk($sformatf("full_drain%0d_d1", i), bus.oData_BM_State1, mk(5'(16 + i)));
      tick;
    end
    chk("full_drain_cnt", bus.oCount, 0);

    // Asynchronous reset between edges, mid-burst
    drive(1, 1, mk(21), 1, 0);
    tick;
    drive(1, 1, mk(22), 1, 0);
    tick;
    chk("pre_arst_cnt", bus.oCount, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_v0",    bus.oValid_BM_State0, 0);
    chk("arst_v1",    bus.oValid_BM_State1, 0);
    chk("arst_cnt",   bus.oCount, 0);
    chk("arst_ready", bus.oReady_AM_Sample, 0);
    chk("arst_d0",    bus.oData_BM_State0, 0);
    chk("arst_d1",    bus.oData_BM_State1, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.iData_AM_Sample = mk(23);
    #1;
    chk("post_arst_v0_pre", bus.oValid_BM_State0, 0);
    tick;
    chk("post_arst_v0", bus.oValid_BM_State0, 1);
    chk("post_arst_d0", bus.oData_BM_State0, mk(23));
    chk("post_arst_v1", bus.oValid_BM_State1, 1);
    chk("post_arst_d1", bus.oData_BM_State1, mk(23));
    chk("post_arst_cnt", bus.oCount, 1);
    drive(0, 0, '0, 1, 1);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
